fetch_stage: RTL and testbench

Instruction-fetch stage. It owns the program counter, drives the instruction-read address of the unified memory, and captures the returned word into the IF/ID pipeline register for decode. The memory's instruction port is combinational and word-addressed, so the word for read_pc is valid in the same cycle. The stage handles stall, branch/jump redirect with flush, and a halt sentinel.

---
 rtl/fetch_stage.sv | 80 ++++++++
 tb/tb_fetch_stage.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses the combinational instruction port,
// and captures the returned word into the IF/ID register. Handles stall, redirect and halt.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   RUN    | fetching sequentially from pc each unstalled cycle
//   HALTED | HALT_WORD was fetched; pc frozen until redirect or reset
module fetch_stage #(
    parameter int          ADDR_W    = 10,
    parameter logic [31:0] RESET_PC  = 32'd0,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic [31:0] instruction_in,
    output logic [31:0] read_pc,
    output logic        ifid_valid,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_pc_plus1,
    output logic [31:0] ifid_instr,
    output logic        halted,
    output logic [31:0] fetch_count
);

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] RESET_PC_W = RESET_PC[ADDR_W-1:0];

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_inc;
    logic              unused_redirect_hi;

    // PC arithmetic wraps naturally at the ADDR_W boundary
    assign pc_inc  = pc + ADDR_W'(1);
    assign read_pc = 32'(pc);
    assign halted  = (state == HALTED);

    // upper target bits are outside the addressable space
    assign unused_redirect_hi = &{1'b0, redirect_pc[31:ADDR_W]};

    always_ff @(posedge clk) begin
        if (rst) begin
            pc            <= RESET_PC_W;
            state         <= RUN;
            ifid_valid    <= 1'b0;
            ifid_pc       <= 32'd0;
            ifid_pc_plus1 <= 32'd0;
            ifid_instr    <= 32'd0;
            fetch_count   <= 32'd0;
        end else if (redirect_valid) begin
            // flush the wrong-path fetch; target is fetched next cycle
            pc         <= redirect_pc[ADDR_W-1:0];
            ifid_valid <= 1'b0;
            state      <= RUN;
        end else if (!stall) begin
            if (state == RUN) begin
                ifid_valid    <= 1'b1;
                ifid_pc       <= 32'(pc);
                ifid_pc_plus1 <= 32'(pc_inc);
                ifid_instr    <= instruction_in;
                fetch_count   <= fetch_count + 32'd1;
                if (instruction_in == HALT_WORD) begin
                    state <= HALTED;
                end else begin
                    pc <= pc_inc;
                end
            end else begin
                ifid_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed test-plan scenarios plus randomized traffic,
// compared every cycle against a behavioural model of the fetch rules.
module tb_fetch_stage;

    localparam int          ADDR_W = 10;
    localparam int          DEPTH  = 1 << ADDR_W;
    localparam logic [31:0] HALT   = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic [31:0] instruction_in;
    logic [31:0] read_pc;
    logic        ifid_valid;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_pc_plus1;
    logic [31:0] ifid_instr;
    logic        halted;
    logic [31:0] fetch_count;

    logic [31:0] mem [DEPTH];

    // model state
    int          m_pc;
    bit          m_halted;
    bit          m_valid;
    int          m_ifpc;
    int          m_ifpc1;
    logic [31:0] m_instr;
    logic [31:0] m_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign instruction_in = mem[read_pc[ADDR_W-1:0]];

    fetch_stage #(.ADDR_W(ADDR_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instruction_in (instruction_in),
        .read_pc        (read_pc),
        .ifid_valid     (ifid_valid),
        .ifid_pc        (ifid_pc),
        .ifid_pc_plus1  (ifid_pc_plus1),
        .ifid_instr     (ifid_instr),
        .halted         (halted),
        .fetch_count    (fetch_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        check("read_pc",       read_pc,             32'(m_pc));
        check("ifid_valid",    32'(ifid_valid),     32'(m_valid));
        check("halted",        32'(halted),         32'(m_halted));
        check("fetch_count",   fetch_count,         m_count);
        check("ifid_pc",       ifid_pc,             32'(m_ifpc));
        check("ifid_pc_plus1", ifid_pc_plus1,       32'(m_ifpc1));
        check("ifid_instr",    ifid_instr,          m_instr);
    endtask

    // Apply one cycle of inputs, advance the model, then compare after the edge.
    task automatic cycle(input bit r, input bit s, input bit rv, input logic [31:0] rp);
        logic [31:0] w;
        rst = r; stall = s; redirect_valid = rv; redirect_pc = rp;
        if (r) begin
            m_pc = 0; m_halted = 0; m_valid = 0;
            m_ifpc = 0; m_ifpc1 = 0; m_instr = 32'd0; m_count = 32'd0;
        end else if (rv) begin
            m_pc = int'(rp % DEPTH); m_valid = 0; m_halted = 0;
        end else if (s) begin
            // everything holds
        end else if (!m_halted) begin
            w = mem[m_pc];
            m_valid = 1; m_ifpc = m_pc; m_ifpc1 = (m_pc + 1) % DEPTH;
            m_instr = w; m_count = m_count + 32'd1;
            if (w == HALT) m_halted = 1;
            else m_pc = (m_pc + 1) % DEPTH;
        end else begin
            m_valid = 0;
        end
        @(posedge clk);
        #1;
        compare_model();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = $urandom;
            if (mem[i] == HALT) mem[i] = 32'h1234_5678;
        end
        mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;
        #2;

        // reset and sequential fetch
        cycle(1, 0, 0, 32'd0);
        check("rst_read_pc", read_pc, 32'd0);
        check("rst_valid", 32'(ifid_valid), 32'd0);
        check("rst_count", fetch_count, 32'd0);
        run(4);
        check("seq_instr", ifid_instr, 32'h44);
        check("seq_pc", ifid_pc, 32'd3);
        check("seq_pc1", ifid_pc_plus1, 32'd4);
        check("seq_count", fetch_count, 32'd4);
        check("seq_read_pc", read_pc, 32'd4);

        // stall for three cycles after edge 2
        cycle(1, 0, 0, 32'd0);
        run(2);
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, 32'd0);
        check("stall_read_pc", read_pc, 32'd2);
        check("stall_instr", ifid_instr, 32'h22);
        check("stall_count", fetch_count, 32'd2);
        run(1);
        check("stall_release", ifid_instr, 32'h33);

        // redirect wins over stall
        cycle(1, 0, 0, 32'd0);
        run(5);
        cycle(0, 1, 1, 32'h100);
        check("redir_valid", 32'(ifid_valid), 32'd0);
        check("redir_read_pc", read_pc, 32'h100);
        run(1);
        check("redir_ifid_pc", ifid_pc, 32'h100);
        check("redir_instr", ifid_instr, mem[32'h100]);

        // halt sentinel
        mem[3] = HALT;
        cycle(1, 0, 0, 32'd0);
        run(4);
        check("halt_instr", ifid_instr, HALT);
        check("halt_valid", 32'(ifid_valid), 32'd1);
        check("halt_flag", 32'(halted), 32'd1);
        check("halt_read_pc", read_pc, 32'd3);
        run(1);
        check("halt_bubble", 32'(ifid_valid), 32'd0);
        check("halt_count", fetch_count, 32'd4);
        cycle(0, 0, 1, 32'd0);
        check("halt_resume", 32'(halted), 32'd0);

        // PC wrap and redirect truncation
        cycle(0, 0, 1, 32'h3FF);
        run(1);
        check("wrap_pc", ifid_pc, 32'h3FF);
        check("wrap_pc1", ifid_pc_plus1, 32'd0);
        check("wrap_read_pc", read_pc, 32'd0);
        cycle(0, 0, 1, 32'hFFFF_F401);
        check("trunc_read_pc", read_pc, 32'd1);

        // reset while halted and stalled
        cycle(1, 0, 0, 32'd0);
        run(5);
        check("pre_rst_halted", 32'(halted), 32'd1);
        cycle(1, 1, 0, 32'd0);
        check("rh_read_pc", read_pc, 32'd0);
        check("rh_valid", 32'(ifid_valid), 32'd0);
        check("rh_halted", 32'(halted), 32'd0);
        check("rh_count", fetch_count, 32'd0);
        mem[3] = 32'h44;

        // randomized traffic with scattered halt words
        for (int i = 0; i < DEPTH; i++)
            if ($urandom_range(99) < 3) mem[i] = HALT;
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(199) == 0,
                  $urandom_range(3) == 0,
                  $urandom_range(19) == 0,
                  $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
